dmem_arbiter: RTL

- Shares the single-port data memory (9-bit word address, 32-bit data) between two requesters: the core load/store port (c_*) and a debug/loader port (d_*).
- Round-robin arbitration; at most one access is issued per cycle.
- Read data is returned to the right requester after a fixed memory latency.
- Sits between the riscv core's wr/rd/addr/wr_data/rd_data signals and the data RAM. It also produces the core stall.

---
 rtl/dmem_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between the core load/store port (c_*)
// and a debug/loader port (d_*). At most one access is issued per cycle and
// conflicts are resolved round-robin. Read data is steered back to the
// requester that issued the read once the memory latency has elapsed.
//
// Handshake (both requester ports):
//   A requester raises req together with we/addr/wdata and holds them stable
//   until it sees gnt=1. The cycle with gnt=1 is the cycle the access is
//   presented to memory. Dropping req before gnt is legal and leaves no trace.
//   Writes complete on the grant cycle. A granted read returns exactly one
//   rvalid pulse RD_LAT+1 cycles later, with rdata registered alongside it;
//   rvalid has no back-pressure. Responses come back in issue order.
//
// Parameters:
//   DATA_W  data width
//   ADDR_W  word address width
//   RD_LAT  cycles from mem_rd to valid mem_rdata (1..3)
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   c_req/c_we/c_addr/c_wdata        core request
//   c_gnt, c_stall                   core grant, core stall (req & ~gnt)
//   c_rvalid/c_rdata                 core read response
//   d_req/d_we/d_addr/d_wdata        debug request
//   d_gnt, d_rvalid/d_rdata          debug grant and read response
//   mem_wr/mem_rd/mem_addr/mem_wdata memory command (same cycle as grant)
//   mem_rdata                        memory read data, RD_LAT after mem_rd
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic OWNER_CORE  = 1'b0;
  localparam logic OWNER_DEBUG = 1'b1;

  // Owner of the most recent granted access; the other port wins a conflict.
  logic last_owner;

  // Arbitration result before reset masking. The flops below only use this
  // when reset is low, so the unmasked form keeps reset out of their data path.
  logic c_pick;
  logic d_pick;
  logic rd_issue;

  // Read tag pipeline: one stage per cycle of memory latency.
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_o;
  logic              tag_out_v;
  logic              tag_out_o;

  // ---------------------------------------------------------------------------
  // Grant
  // ---------------------------------------------------------------------------
  always_comb begin
    c_pick = 1'b0;
    d_pick = 1'b0;
    if (c_req && d_req) begin
      if (last_owner == OWNER_DEBUG) c_pick = 1'b1;
      else                           d_pick = 1'b1;
    end else if (c_req) begin
      c_pick = 1'b1;
    end else if (d_req) begin
      d_pick = 1'b1;
    end
  end

  // No grant may be visible while reset is held.
  assign c_gnt   = c_pick & ~reset;
  assign d_gnt   = d_pick & ~reset;
  assign c_stall = c_req & ~c_gnt;

  assign rd_issue = (c_pick & ~c_we) | (d_pick & ~d_we);

  // ---------------------------------------------------------------------------
  // Memory command mux: fields of the granted port, all zero when idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (c_gnt) begin
      mem_wr    = c_we;
      mem_rd    = ~c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (d_gnt) begin
      mem_wr    = d_we;
      mem_rd    = ~d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin state; held on idle cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= OWNER_DEBUG;
    end else if (c_pick) begin
      last_owner <= OWNER_CORE;
    end else if (d_pick) begin
      last_owner <= OWNER_DEBUG;
    end
  end

  // ---------------------------------------------------------------------------
  // Read tag pipeline. A tag enters on the grant edge and reaches the last
  // stage in the cycle where mem_rdata carries its data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v[0] <= rd_issue;
      tag_o[0] <= d_pick;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end
    end
  end

  assign tag_out_v = tag_v[RD_LAT-1];
  assign tag_out_o = tag_o[RD_LAT-1];

  // ---------------------------------------------------------------------------
  // Response registers: rdata holds until that owner's next response.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= tag_out_v & (tag_out_o == OWNER_CORE);
      d_rvalid <= tag_out_v & (tag_out_o == OWNER_DEBUG);
      if (tag_out_v && (tag_out_o == OWNER_CORE))  c_rdata <= mem_rdata;
      if (tag_out_v && (tag_out_o == OWNER_DEBUG)) d_rdata <= mem_rdata;
    end
  end

endmodule
